// File: rtl/sdram_svga_pkg.sv
// Shared defaults for the SDRAM-to-SVGA datapath blocks.
// Covers line buffer width, depth and almost-full threshold.
package sdram_svga_pkg;
  localparam int unsigned FIFO_DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH_LOG2 = 5;
  localparam int unsigned FIFO_AF_LEVEL   = 24;
endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// The read register clears on reset and holds its value when no read is enabled.
module fifo_dp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The FIFO's flag rules never read and write the same address in one cycle,
  // so no read-during-write ordering is required here.
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/line_fifo.sv
// Single-clock line FIFO between the SDRAM burst engine and SVGA pixel fetch.
// Define LINE_FIFO_ERR_EN to add sticky OVF/UDF error outputs.
module line_fifo
  import sdram_svga_pkg::*;
#(
  parameter int unsigned DATA_W     = FIFO_DATA_W,
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int unsigned AF_LEVEL   = FIFO_AF_LEVEL
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  WRn,
  input  logic [DATA_W-1:0]     DATA_WR,
  input  logic                  RDn,
  output logic [DATA_W-1:0]     DATA_RD,
  output logic                  VALID_RD,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic [DEPTH_LOG2:0]   LEVEL
`ifdef LINE_FIFO_ERR_EN
  ,
  output logic                  OVF,
  output logic                  UDF
`endif
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_lvl_nxt;
  logic          w_wr_acc, w_rd_acc;
  logic          r_full, r_empty, r_af, r_valid;

  // Flags are registered from the next pointer pair so they line up with LEVEL.
  always_comb begin
    w_wr_acc  = ~WRn && !r_full  && !FLUSH && !RST;
    w_rd_acc  = ~RDn && !r_empty && !FLUSH && !RST;
    w_wr_nxt  = r_wr_ptr;
    w_rd_nxt  = r_rd_ptr;
    if (FLUSH) begin
      w_wr_nxt = '0;
      w_rd_nxt = '0;
    end else begin
      if (w_wr_acc) w_wr_nxt = r_wr_ptr + PW'(1);
      if (w_rd_acc) w_rd_nxt = r_rd_ptr + PW'(1);
    end
    w_lvl_nxt = w_wr_nxt - w_rd_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_full   <= (w_lvl_nxt == PW'(DEPTH));
      r_empty  <= (w_lvl_nxt == '0);
      r_af     <= (w_lvl_nxt >= PW'(AF_LEVEL));
      r_valid  <= w_rd_acc;
    end
  end

  fifo_dp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (DATA_WR),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (DATA_RD)
  );

  assign VALID_RD    = r_valid;
  assign FULL        = r_full;
  assign EMPTY       = r_empty;
  assign ALMOST_FULL = r_af;
  assign LEVEL       = r_wr_ptr - r_rd_ptr;

`ifdef LINE_FIFO_ERR_EN
  logic r_ovf, r_udf;

  // Sticky: only RST clears them, FLUSH leaves them set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (~WRn && r_full)  r_ovf <= 1'b1;
      if (~RDn && r_empty) r_udf <= 1'b1;
    end
  end

  assign OVF = r_ovf;
  assign UDF = r_udf;
`endif
endmodule

// File: tb/tb_line_fifo.sv
// Self-checking bench for line_fifo: queue-based reference model plus directed scenarios
// and a randomized phase; honours LINE_FIFO_ERR_EN when defined.
module tb_line_fifo;
  localparam int DW    = 16;
  localparam int DL2   = 5;
  localparam int DEPTH = 32;
  localparam int AFL   = 24;

  logic          CLK = 1'b0;
  logic          RST = 1'b0, FLUSH = 1'b0, WRn = 1'b1, RDn = 1'b1;
  logic [DW-1:0] DATA_WR = '0;
  logic [DW-1:0] DATA_RD;
  logic          VALID_RD, FULL, EMPTY, ALMOST_FULL;
  logic [DL2:0]  LEVEL;
`ifdef LINE_FIFO_ERR_EN
  logic          OVF, UDF;
`endif

  line_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL2), .AF_LEVEL(AFL)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .WRn(WRn), .DATA_WR(DATA_WR), .RDn(RDn),
    .DATA_RD(DATA_RD), .VALID_RD(VALID_RD), .FULL(FULL), .EMPTY(EMPTY),
    .ALMOST_FULL(ALMOST_FULL), .LEVEL(LEVEL)
`ifdef LINE_FIFO_ERR_EN
    , .OVF(OVF), .UDF(UDF)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Reference model: contents as a queue, outputs derived from its size.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data  = '0;
  bit            m_valid = 0, m_ovf = 0, m_udf = 0, m_init = 0;

  always @(posedge CLK) begin : model
    bit was_full, was_empty;
    if (RST) begin
      q.delete();
      m_data = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_init = 1;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (!WRn && was_full)  m_ovf = 1;
      if (!RDn && was_empty) m_udf = 1;
      m_valid = 0;
      if (FLUSH) q.delete();
      else begin
        if (!RDn && !was_empty) begin
          m_data  = q.pop_front();
          m_valid = 1;
        end
        if (!WRn && !was_full) q.push_back(DATA_WR);
      end
    end
  end

  always @(negedge CLK) begin
    if (m_init) begin
      chk("level", int'(LEVEL), q.size());
      chk("full",  int'(FULL),  int'(q.size() == DEPTH));
      chk("empty", int'(EMPTY), int'(q.size() == 0));
      chk("afull", int'(ALMOST_FULL), int'(q.size() >= AFL));
      chk("valid", int'(VALID_RD), int'(m_valid));
      chk("data",  int'(DATA_RD), int'(m_data));
`ifdef LINE_FIFO_ERR_EN
      chk("ovf", int'(OVF), int'(m_ovf));
      chk("udf", int'(UDF), int'(m_udf));
`endif
    end
  end

  // One clock cycle with the given strobes; returns just after the next falling edge.
  task automatic cyc(input logic rst, input logic fl, input logic wrn,
                     input logic [DW-1:0] d, input logic rdn);
    RST = rst; FLUSH = fl; WRn = wrn; DATA_WR = d; RDn = rdn;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; FLUSH = 1'b0; WRn = 1'b1; RDn = 1'b1;
  endtask

  logic [DW-1:0] first_word;

  initial begin
    @(negedge CLK);
    cyc(1, 0, 1, '0, 1);
    cyc(1, 0, 1, '0, 1);
    chk("rst_level", int'(LEVEL), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_data", int'(DATA_RD), 0);

    // Fill with 1..32; ALMOST_FULL from the 24th word, FULL after the 32nd.
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 0, 0, DW'(k), 1);
      chk("fill_af", int'(ALMOST_FULL), int'(k >= 24));
    end
    chk("fill_full", int'(FULL), 1);
    chk("fill_level", int'(LEVEL), 32);

    cyc(0, 0, 0, 16'hDEAD, 1);
    chk("ovr_level", int'(LEVEL), 32);
`ifdef LINE_FIFO_ERR_EN
    chk("ovr_ovf", int'(OVF), 1);
    cyc(0, 0, 1, '0, 1);
    chk("ovr_ovf_sticky", int'(OVF), 1);
`endif

    for (int k = 1; k <= 32; k++) begin
      cyc(0, 0, 1, '0, 0);
      chk("drain_data", int'(DATA_RD), k);
      chk("drain_valid", int'(VALID_RD), 1);
    end
    chk("drain_empty", int'(EMPTY), 1);
    cyc(0, 0, 1, '0, 1);
    chk("idle_valid", int'(VALID_RD), 0);

    // Simultaneous R/W on empty: write only, no fall-through.
    cyc(0, 0, 0, 16'h1234, 0);
    chk("emp_rw_level", int'(LEVEL), 1);
    chk("emp_rw_valid", int'(VALID_RD), 0);
`ifdef LINE_FIFO_ERR_EN
    chk("emp_rw_udf", int'(UDF), 1);
`endif
    cyc(0, 0, 1, '0, 0);
    chk("emp_rw_data", int'(DATA_RD), 16'h1234);

    // Simultaneous R/W on full: read only.
    for (int k = 0; k < 32; k++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      if (k == 0) first_word = v;
      cyc(0, 0, 0, v, 1);
    end
    cyc(0, 0, 0, 16'hBEEF, 0);
    chk("full_rw_level", int'(LEVEL), 31);
    chk("full_rw_data", int'(DATA_RD), int'(first_word));
    for (int k = 0; k < 15; k++) cyc(0, 0, 1, '0, 0);
    chk("stream_start", int'(LEVEL), 16);
    for (int k = 0; k < 100; k++) cyc(0, 0, 0, DW'($urandom), 0);
    chk("stream_level", int'(LEVEL), 16);

    // Flush at level 10 with a concurrent write.
    cyc(0, 1, 1, '0, 1);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, DW'(k + 100), 1);
    chk("pre_flush_level", int'(LEVEL), 10);
    cyc(0, 1, 0, 16'h5555, 1);
    chk("flush_level", int'(LEVEL), 0);
    chk("flush_empty", int'(EMPTY), 1);

    // Reset arriving together with a read strobe.
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, DW'(k + 7), 1);
    cyc(0, 0, 1, '0, 0);
    chk("pre_rst_data", int'(DATA_RD), 7);
    cyc(1, 0, 1, '0, 0);
    chk("rst_rd_data", int'(DATA_RD), 0);
    chk("rst_rd_valid", int'(VALID_RD), 0);
    chk("rst_rd_level", int'(LEVEL), 0);
`ifdef LINE_FIFO_ERR_EN
    chk("rst_ovf", int'(OVF), 0);
    chk("rst_udf", int'(UDF), 0);
`endif

    // Randomized phases: write-heavy, read-heavy, balanced.
    for (int ph = 0; ph < 12; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
      rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 55;
      for (int n = 0; n < 150; n++) begin
        cyc(logic'($urandom_range(0, 999) == 0), logic'($urandom_range(0, 199) == 0),
            logic'($urandom_range(0, 99) >= wp), DW'($urandom),
            logic'($urandom_range(0, 99) >= rp));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
